// File: rtl/pipe_fifo.sv
// pipe_fifo: FWFT valid/ready FIFO buffering words ahead of the datapath pipeline; optional PIPE_FIFO_HWM_EN adds hwm.
// Latency: a word pushed at edge N is presented in cycle N+1; no empty-bypass path.
// Backpressure: in_ready/out_valid decode from registered count only, so a full FIFO frees its slot the cycle after a pop.
module pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_FIFO_HWM_EN
  output logic [CNT_W-1:0] hwm,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; out_data gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef PIPE_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (count_q > hwm_q) hwm_d = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_pipe_fifo.sv
// Self-checking bench for pipe_fifo: directed vector table, corner sequences, and random traffic against a queue model.
module tb_pipe_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
`ifdef PIPE_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm;
`endif

  pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_FIFO_HWM_EN
    .hwm       (hwm),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a bounded queue of accepted words plus a running maximum.
  logic [WIDTH-1:0] m_q[$];
  int               m_hwm = 0;
  logic [WIDTH-1:0] popped[$];

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             orr;
    logic             ev;
    logic             er;
    logic [CNT_W-1:0] ec;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(sz < DEPTH));
    chk({tag, ".count"},     32'(count),     32'(sz));
    chk({tag, ".out_data"},  32'(out_data),  (sz > 0) ? 32'(m_q[0]) : 32'd0);
`ifdef PIPE_FIFO_HWM_EN
    chk({tag, ".hwm"},       32'(hwm),       32'(m_hwm));
`endif
  endtask

  // Drive one cycle of inputs, advance past the edge, and update the model.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    logic do_push, do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push = v && (m_q.size() < DEPTH);
    do_pop  = r && (m_q.size() > 0);
    if (do_pop) popped.push_back(out_data);
    if (m_q.size() > m_hwm) m_hwm = m_q.size();
    @(posedge clk);
    #1;
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(d);
  endtask

  task automatic pulse_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    m_q.delete();
    m_hwm = 0;
    chk("async_rst.count",     32'(count),     32'd0);
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.in_ready",  32'(in_ready),  32'd1);
    chk("async_rst.out_data",  32'(out_data),  32'd0);
`ifdef PIPE_FIFO_HWM_EN
    chk("async_rst.hwm",       32'(hwm),       32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    rst = 1'b0;

    // Fill, reject on full, pop-while-full, drain, empty pops.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 3'd4, 8'h11};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 3'd4, 8'h11};
    tbl[5]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 3'd3, 8'h22};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h33};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h44};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].orr);
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].er));
      chk($sformatf("tbl%0d.count", i),     32'(count),     32'(tbl[i].ec));
      chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].ed));
    end
    chk("drain.n_popped", 32'(popped.size()), 32'd4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      chk($sformatf("drain.word%0d", i), 32'(popped[i]), 32'(8'h11 * (i + 1)));

    // After empty pops, a fresh push must be the head word.
    step(1'b1, 8'h77, 1'b0);
    chk("post_empty.out_data", 32'(out_data), 32'h77);
    step(1'b0, 8'h00, 1'b1);
    chk_model("post_empty.drain");

    // Streaming: continuous push and pop, pointers wrap twice.
    popped.delete();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d.out_data", i), 32'(out_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    chk_model("stream.end");
    chk("stream.n_popped", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      chk($sformatf("stream.word%0d", i), 32'(popped[i]), 32'(i + 1));

    // Mid-stream reset with three words buffered.
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    chk("pre_rst.count", 32'(count), 32'd3);
    pulse_reset();
    chk_model("post_rst");
    step(1'b1, 8'hA5, 1'b0);
    chk("first_after_rst.out_valid", 32'(out_valid), 32'd1);
    chk("first_after_rst.out_data",  32'(out_data),  32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk_model("first_after_rst.drain");

`ifdef PIPE_FIFO_HWM_EN
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hBF, 1'b0);
    chk("hwm.after_seq", 32'(hwm), 32'd3);
    step(1'b0, 8'h00, 1'b1);
    pulse_reset();
    chk("hwm.after_rst", 32'(hwm), 32'd0);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50));
      chk_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_fifo.md
Name: pipe_fifo

Overview:
- Small synchronous FIFO with valid/ready handshake on both sides.
- Buffers data words between a producer and the datapath register stages (8-/16-bit DFF pipeline). It absorbs stalls so upstream need not stop on every downstream hold.
- Single clock domain. First-word-fall-through: the head entry is presented on out_data whenever out_valid is high.

Parameters:
- WIDTH, 8, data word width in bits (1..16 supported).
- DEPTH, 4, number of entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  FIFO can accept a word this cycle
- in_data  input  WIDTH  write data
- out_valid  output  1  FIFO holds at least one word
- out_ready  input  1  consumer takes the head word this cycle
- out_data  output  WIDTH  head word; 0 when empty
- count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - Asserting rst immediately clears the read pointer, write pointer and count.
  - Outputs go to out_valid=0, in_ready=1, count=0, out_data=0.
  - Storage array contents are not reset.
- Push: occurs when in_valid && in_ready at a rising edge. in_data is written at wr_ptr, wr_ptr advances and wraps modulo DEPTH.
- Pop: occurs when out_valid && out_ready at a rising edge. rd_ptr advances and wraps modulo DEPTH.
- Ready/valid decode:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - Both are derived from registered count only, with no combinational path from in_valid or out_ready.
- Latency: a word pushed at edge N sets out_valid after edge N (visible in cycle N+1). There is no combinational pass-through when empty.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full (count==DEPTH): in_ready=0. in_valid is ignored and storage is unchanged. A pop in the same cycle does not free the slot until the next cycle, so no push is accepted that cycle.
  - Empty (count==0): out_valid=0 and out_ready is ignored. out_data=0.
  - Simultaneous push and pop at 0<count<DEPTH: both pointers advance and ordering is preserved.
  - Pointer wrap: after DEPTH pushes wr_ptr returns to 0. Ordering holds across the wrap.
- Data handling:
  - out_data comes from the storage entry at rd_ptr, gated to 0 when count==0.
  - in_data is never altered. Words leave in the order they were accepted.
- Handshake stability: out_data and out_valid change only on clock edges or on rst assertion.
- Reset mid-operation: all buffered words are discarded. After rst deasserts, the first push is again the first word out.

Optional Feature:
- Macro PIPE_FIFO_HWM_EN.
- Defined:
  - Adds output port hwm (CNT_W bits), the high-water mark of count since reset.
  - hwm updates on the edge after count exceeds it and never decreases.
  - rst clears it to 0.
- Not defined: the hwm port and its register do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 mid-stream with count=3, then release -> immediately count=0, out_valid=0, in_ready=1, out_data=0. Then push 0xA5 -> out_valid=1 and out_data=0xA5 next cycle.
- Fill to full: DEPTH=4, push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0. Push 0x55 is rejected. Draining yields 0x11,0x22,0x33,0x44, then out_valid=0.
- Full plus simultaneous pop: with count=4, assert in_valid with 0x66 and out_ready=1 in the same cycle -> 0x11 is popped, 0x66 is not accepted, count=3. Next cycle in_ready=1.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 words 0x01..0x0A -> steady-state count=1, every word appears exactly once in order, pointers wrap at least twice.
- Empty pop: count=0, out_ready=1 for 3 cycles -> count stays 0, pointers unchanged, out_data=0.
- PIPE_FIFO_HWM_EN defined: push 3 words, pop all, push 1 -> hwm=3. After rst, hwm=0.
